seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed N-digit seven-segment display driver. Successor to the single-digit hex decoder.
- Latches a packed hex word, its decimal-point bits and its blank bits.
- Scans the digits round-robin with a programmable refresh divider and drives shared active-low cathodes plus per-digit active-low anodes.
- Updates are tear-free: new content takes effect only at a frame boundary. Sits between the datapath and the board display pins.

---
 rtl/seg7_scan_driver_if.sv | 23 ++
 rtl/seg7_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Datapath-side and pin-side signals of the multiplexed seven-segment driver.
interface seg7_scan_driver_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    load;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_start;

   modport master (
      output value, dp_in, blank_in, load,
      input  seg, dp, an, frame_start
   );

   modport slave (
      input  value, dp_in, blank_in, load,
      output seg, dp, an, frame_start
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-aligned (tear-free) updates.
// Optional leading-zero suppression when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input logic               clk,
   input logic               reset,
   seg7_scan_driver_if.slave bus
);
   localparam int unsigned VAL_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DIV_W = $clog2(REFRESH_DIV);

   logic [DIV_W-1:0]      div_q, div_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      pend_val_q, pend_val_d, disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
   logic                  pend_vld_q, pend_vld_d, disp_vld_q, disp_vld_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_start_q, frame_start_d;
   logic                  terminal_c, boundary_c, lz_c;
   logic [3:0]            nib_c;

   // Active-low segment pattern, bit6..bit0 = g..a.
   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0:    decode = 7'h40;
         4'h1:    decode = 7'h79;
         4'h2:    decode = 7'h24;
         4'h3:    decode = 7'h30;
         4'h4:    decode = 7'h19;
         4'h5:    decode = 7'h12;
         4'h6:    decode = 7'h02;
         4'h7:    decode = 7'h78;
         4'h8:    decode = 7'h00;
         4'h9:    decode = 7'h18;
         4'hA:    decode = 7'h08;
         4'hB:    decode = 7'h03;
         4'hC:    decode = 7'h46;
         4'hD:    decode = 7'h21;
         4'hE:    decode = 7'h06;
         default: decode = 7'h0E;
      endcase
   endfunction

   always_comb begin
      div_d         = div_q;
      idx_d         = idx_q;
      pend_val_d    = pend_val_q;
      pend_dp_d     = pend_dp_q;
      pend_blank_d  = pend_blank_q;
      pend_vld_d    = pend_vld_q;
      disp_val_d    = disp_val_q;
      disp_dp_d     = disp_dp_q;
      disp_blank_d  = disp_blank_q;
      disp_vld_d    = disp_vld_q;
      an_d          = '1;
      seg_d         = 7'h7F;
      dp_d          = 1'b1;
      lz_c          = 1'b0;
      nib_c         = 4'h0;

      terminal_c    = (div_q == DIV_W'(REFRESH_DIV - 1));
      boundary_c    = terminal_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
      frame_start_d = boundary_c;

      div_d = terminal_c ? '0 : div_q + DIV_W'(1);
      if (terminal_c)
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

      // Loads land in the shadow; only the frame boundary moves content to the display.
      if (boundary_c) begin
         pend_vld_d = 1'b0;
         if (bus.load) begin
            disp_val_d   = bus.value;
            disp_dp_d    = bus.dp_in;
            disp_blank_d = bus.blank_in;
            disp_vld_d   = 1'b1;
         end else if (pend_vld_q) begin
            disp_val_d   = pend_val_q;
            disp_dp_d    = pend_dp_q;
            disp_blank_d = pend_blank_q;
            disp_vld_d   = 1'b1;
         end
      end else if (bus.load) begin
         pend_val_d   = bus.value;
         pend_dp_d    = bus.dp_in;
         pend_blank_d = bus.blank_in;
         pend_vld_d   = 1'b1;
      end

      nib_c = disp_val_d[4*int'(idx_d) +: 4];

`ifdef SEG7_LZ_BLANK_EN
      // Suppressed when this and every more-significant nibble is zero; digit 0 always shows.
      begin
         logic upper_nz;
         upper_nz = 1'b0;
         for (int i = 0; i < int'(NUM_DIGITS); i++)
            if (i >= int'(idx_d) && disp_val_d[4*i +: 4] != 4'h0)
               upper_nz = 1'b1;
         lz_c = (idx_d != '0) && !upper_nz;
      end
`else
      lz_c = 1'b0;
`endif

      if (disp_vld_d) begin
         an_d = ~(NUM_DIGITS'(1) << idx_d);
         if (!disp_blank_d[idx_d]) begin
            dp_d = ~disp_dp_d[idx_d];
            if (!lz_c)
               seg_d = decode(nib_c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         idx_q         <= '0;
         pend_val_q    <= '0;
         pend_dp_q     <= '0;
         pend_blank_q  <= '0;
         pend_vld_q    <= 1'b0;
         disp_val_q    <= '0;
         disp_dp_q     <= '0;
         disp_blank_q  <= '0;
         disp_vld_q    <= 1'b0;
         an_q          <= '1;
         seg_q         <= 7'h7F;
         dp_q          <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         idx_q         <= idx_d;
         pend_val_q    <= pend_val_d;
         pend_dp_q     <= pend_dp_d;
         pend_blank_q  <= pend_blank_d;
         pend_vld_q    <= pend_vld_d;
         disp_val_q    <= disp_val_d;
         disp_dp_q     <= disp_dp_d;
         disp_blank_q  <= disp_blank_d;
         disp_vld_q    <= disp_vld_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.an          = an_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios then random traffic, against a frame-position model.
module tb_seg7_scan_driver;
   localparam int unsigned ND    = 4;
   localparam int unsigned RD    = 4;
   localparam int unsigned FRAME = ND * RD;

   logic clk = 1'b0;
   logic reset;

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [6:0] seg_rom [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Model: position within the frame is simply cycles-since-reset modulo the frame length.
   int          cyc;
   bit          pend_v, disp_v;
   logic [15:0] pend_val, disp_val;
   logic [3:0]  pend_dp, disp_dp, pend_bl, disp_bl;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, obs, exp, $time, cyc);
      end
   endtask

   task automatic tick(input logic rst, input logic ld, input logic [15:0] v,
                       input logic [3:0] d, input logic [3:0] b);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp, e_fs;
      int         slot, msd;
      logic [3:0] nib;
      reset        = rst;
      bus.load     = ld;
      bus.value    = v;
      bus.dp_in    = d;
      bus.blank_in = b;
      @(posedge clk);
      if (rst) begin
         cyc    = 0;
         pend_v = 0;
         disp_v = 0;
      end else begin
         if (ld && (cyc % FRAME == FRAME - 1)) begin
            disp_val = v; disp_dp = d; disp_bl = b; disp_v = 1; pend_v = 0;
         end else if (ld) begin
            pend_val = v; pend_dp = d; pend_bl = b; pend_v = 1;
         end else if (pend_v && (cyc % FRAME == FRAME - 1)) begin
            disp_val = pend_val; disp_dp = pend_dp; disp_bl = pend_bl; disp_v = 1; pend_v = 0;
         end
         cyc++;
      end
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_fs  = !rst && (cyc % FRAME == 0);
      slot  = (cyc % FRAME) / RD;
      if (disp_v) begin
         e_an = 4'hF;
         e_an[slot] = 1'b0;
         msd = 0;
         for (int i = 0; i < int'(ND); i++)
            if (disp_val[4*i +: 4] != 4'h0) msd = i;
         nib = disp_val[4*slot +: 4];
         if (!disp_bl[slot]) begin
            e_dp  = ~disp_dp[slot];
            e_seg = seg_rom[nib];
`ifdef SEG7_LZ_BLANK_EN
            if (slot > msd) e_seg = 7'h7F;
`endif
         end
      end
      #1;
      check("an", 32'(bus.an), 32'(e_an));
      check("seg", 32'(bus.seg), 32'(e_seg));
      check("dp", 32'(bus.dp), 32'(e_dp));
      check("frame_start", 32'(bus.frame_start), 32'(e_fs));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
   endtask

   // Advance so that the next tick is issued at the given frame position.
   task automatic go_to(input int pos);
      for (int i = 0; i < int'(FRAME) && (cyc % FRAME) != pos; i++) idle(1);
   endtask

   initial begin
      cyc = 0; pend_v = 0; disp_v = 0;
      pend_val = '0; disp_val = '0; pend_dp = '0; disp_dp = '0; pend_bl = '0; disp_bl = '0;
      tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(40);

      go_to(8);
      tick(1'b0, 1'b1, 16'h12A0, 4'b0100, 4'b0000);
      idle(2 * FRAME);

      go_to(2);
      tick(1'b0, 1'b1, 16'h1111, 4'b0000, 4'b0000);
      idle(3);
      tick(1'b0, 1'b1, 16'h2222, 4'b0000, 4'b0000);
      idle(2 * FRAME);

      go_to(FRAME - 1);
      tick(1'b0, 1'b1, 16'hFFFF, 4'b0000, 4'b0000);
      idle(FRAME + 4);

      tick(1'b0, 1'b1, 16'h8888, 4'b0000, 4'b1000);
      idle(2 * FRAME);

      go_to(6);
      tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(20);
      tick(1'b0, 1'b1, 16'h0005, 4'b0000, 4'b0000);
      idle(2 * FRAME);

      tick(1'b0, 1'b1, 16'h0000, 4'b0011, 4'b0000);
      idle(2 * FRAME);

      for (int n = 0; n < 1500; n++) begin
         int r;
         r = int'($urandom_range(0, 199));
         if (r == 0)
            tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
         else if (r < 25)
            tick(1'b0, 1'b1, 16'($urandom), 4'($urandom), (r < 8) ? 4'($urandom) : 4'h0);
         else
            idle(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
